// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: multi-cycle multiply/divide sequencer that owns the HI/LO pair.
// Runs WIDTH-iteration shift-add multiply and restoring divide on operand
// magnitudes, then applies sign correction / MADD-MSUB accumulation at FIXUP.
// Ports:
//   Clk, Reset_n         clock, asynchronous active-low reset
//   Start, Op, A, B      request, opcode, rs/rt operands (sampled at accept only)
//   Flush                abort in-flight operation (also blocks a same-cycle Start)
//   ReadHiLo             MFHI/MFLO in ID this cycle
//   Busy                 operation in flight (RUN or FIXUP)
//   Stall                combinational: Busy & (Start | ReadHiLo)
//   Done, DivByZero      1-cycle pulses the cycle after the HI/LO commit
//   Hi, Lo               current HI/LO registers
module hilo_muldiv_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Flush,
    input  logic             ReadHiLo,
    output logic             Busy,
    output logic             Stall,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned DW = 2 * WIDTH;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MADD  = 3'b110;
    localparam logic [2:0] OP_MSUB  = 3'b111;

    typedef enum logic [1:0] {IDLE, RUN, FIXUP} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    count, count_nxt;
    logic [2:0]       op_q, op_q_nxt;
    logic [WIDTH-1:0] opa, opa_nxt, opb, opb_nxt;
    logic [WIDTH-1:0] acc_hi, acc_hi_nxt, acc_lo, acc_lo_nxt;
    logic [WIDTH-1:0] hi, hi_nxt, lo, lo_nxt;
    logic             res_neg, res_neg_nxt, rem_neg, rem_neg_nxt;
    logic             b_zero, b_zero_nxt;
    logic             busy, busy_nxt, done, done_nxt, dbz, dbz_nxt;

    // Accept-time operand conditioning
    logic             in_signed, in_div, in_a_neg, in_b_neg;
    logic [WIDTH-1:0] in_a_abs, in_b_abs;
    assign in_signed = (Op == OP_MULT) || (Op == OP_DIV) || (Op == OP_MADD) || (Op == OP_MSUB);
    assign in_div    = (Op == OP_DIV) || (Op == OP_DIVU);
    assign in_a_neg  = in_signed & A[WIDTH-1];
    assign in_b_neg  = in_signed & B[WIDTH-1];
    assign in_a_abs  = in_a_neg ? (~A + WIDTH'(1)) : A;
    assign in_b_abs  = in_b_neg ? (~B + WIDTH'(1)) : B;

    // One multiply step: conditional add of multiplicand, then shift {acc_hi,acc_lo} right
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opa} : {(WIDTH+1){1'b0}});

    // One restoring-divide step: shift next dividend bit into remainder, trial subtract
    logic [WIDTH:0] div_shift, div_diff;
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opb};

    // Sign-corrected results consumed at FIXUP
    logic             op_is_div;
    logic [DW-1:0]    prod_mag, prod_signed, hilo_old;
    logic [WIDTH-1:0] quo_s, rem_s, a_orig;
    assign op_is_div   = (op_q == OP_DIV) || (op_q == OP_DIVU);
    assign prod_mag    = {acc_hi, acc_lo};
    assign prod_signed = res_neg ? (~prod_mag + DW'(1)) : prod_mag;
    assign hilo_old    = {hi, lo};
    assign quo_s       = res_neg ? (~acc_lo + WIDTH'(1)) : acc_lo;
    assign rem_s       = rem_neg ? (~acc_hi + WIDTH'(1)) : acc_hi;
    assign a_orig      = rem_neg ? (~opa + WIDTH'(1)) : opa;

    // State and datapath registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            count   <= '0;
            op_q    <= '0;
            opa     <= '0;
            opb     <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            hi      <= '0;
            lo      <= '0;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
            b_zero  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            dbz     <= 1'b0;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            op_q    <= op_q_nxt;
            opa     <= opa_nxt;
            opb     <= opb_nxt;
            acc_hi  <= acc_hi_nxt;
            acc_lo  <= acc_lo_nxt;
            hi      <= hi_nxt;
            lo      <= lo_nxt;
            res_neg <= res_neg_nxt;
            rem_neg <= rem_neg_nxt;
            b_zero  <= b_zero_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            dbz     <= dbz_nxt;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        op_q_nxt    = op_q;
        opa_nxt     = opa;
        opb_nxt     = opb;
        acc_hi_nxt  = acc_hi;
        acc_lo_nxt  = acc_lo;
        hi_nxt      = hi;
        lo_nxt      = lo;
        res_neg_nxt = res_neg;
        rem_neg_nxt = rem_neg;
        b_zero_nxt  = b_zero;
        done_nxt    = 1'b0;
        dbz_nxt     = 1'b0;

        case (state)
            IDLE: begin
                if (Start && !Flush) begin
                    if (Op == OP_MTHI) begin
                        hi_nxt = A;
                    end else if (Op == OP_MTLO) begin
                        lo_nxt = A;
                    end else begin
                        op_q_nxt    = Op;
                        opa_nxt     = in_a_abs;
                        opb_nxt     = in_b_abs;
                        res_neg_nxt = in_a_neg ^ in_b_neg;
                        rem_neg_nxt = in_a_neg;
                        b_zero_nxt  = (B == '0);
                        acc_hi_nxt  = '0;
                        acc_lo_nxt  = in_div ? in_a_abs : in_b_abs;
                        count_nxt   = '0;
                        state_nxt   = RUN;
                    end
                end
            end
            RUN: begin
                if (Flush) begin
                    state_nxt = IDLE;
                end else begin
                    if (op_is_div) begin
                        if (!div_diff[WIDTH]) begin
                            acc_hi_nxt = div_diff[WIDTH-1:0];
                            acc_lo_nxt = {acc_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_hi_nxt = div_shift[WIDTH-1:0];
                            acc_lo_nxt = {acc_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_hi_nxt = mul_sum[WIDTH:1];
                        acc_lo_nxt = {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                    count_nxt = count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        state_nxt = FIXUP;
                    end
                end
            end
            FIXUP: begin
                state_nxt = IDLE;
                if (!Flush) begin
                    done_nxt = 1'b1;
                    case (op_q)
                        OP_MULT, OP_MULTU: {hi_nxt, lo_nxt} = prod_signed;
                        OP_MADD:           {hi_nxt, lo_nxt} = hilo_old + prod_signed;
                        OP_MSUB:           {hi_nxt, lo_nxt} = hilo_old - prod_signed;
                        default: begin
                            if (b_zero) begin
                                lo_nxt  = '1;
                                hi_nxt  = a_orig;
                                dbz_nxt = 1'b1;
                            end else begin
                                lo_nxt = quo_s;
                                hi_nxt = rem_s;
                            end
                        end
                    endcase
                end
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    assign Busy      = busy;
    assign Stall     = busy & (Start | ReadHiLo);
    assign Done      = done;
    assign DivByZero = dbz;
    assign Hi        = hi;
    assign Lo        = lo;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Scoreboard bench for hilo_muldiv_ctrl: the driver pushes expected HI/LO/DivByZero
// per issued operation; the monitor pops and compares on every Done pulse.
module tb_hilo_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, flush, read_hilo;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, stall, done, dbz;
    logic [31:0] hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    bit   prev_done = 1'b0;

    hilo_muldiv_ctrl #(.WIDTH(32)) dut (
        .Clk(clk), .Reset_n(rst_n), .Start(start), .Op(op), .A(a), .B(b),
        .Flush(flush), .ReadHiLo(read_hilo), .Busy(busy), .Stall(stall),
        .Done(done), .DivByZero(dbz), .Hi(hi), .Lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: compare every Done against the oldest expectation
    always @(negedge clk) begin
        if (prev_done) chk("done_width", 64'(done), 64'(0));
        prev_done = (done === 1'b1);
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'(done), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_hi",  64'(hi),  64'(e.hi));
                chk("sb_lo",  64'(lo),  64'(e.lo));
                chk("sb_dbz", 64'(dbz), 64'(e.dbz));
            end
        end else if (dbz === 1'b1) begin
            chk("dbz_without_done", 64'(dbz), 64'(0));
        end
    end

    // Issue a multi-cycle op at the current negedge; return at the Done-cycle negedge
    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] oa,
                          input logic [31:0] ob, input logic [31:0] ehi,
                          input logic [31:0] elo, input logic edbz);
        int n;
        exp_t e;
        e.hi = ehi; e.lo = elo; e.dbz = edbz;
        sb.push_back(e);
        start = 1'b1; op = o; a = oa; b = ob;
        @(negedge clk);
        start = 1'b0; a = 32'hDEADBEEF; b = 32'h0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({name, "_busy_cycles"}, 64'(n), 64'(33));
        chk({name, "_done"}, 64'(done), 64'(1));
    endtask

    // MTHI/MTLO: single-edge write, no Busy/Done
    task automatic run_mt(input string name, input logic [2:0] o, input logic [31:0] oa);
        start = 1'b1; op = o; a = oa;
        @(negedge clk);
        start = 1'b0; a = 32'h0;
        chk({name, "_busy"}, 64'(busy), 64'(0));
        chk({name, "_done"}, 64'(done), 64'(0));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; read_hilo = 1'b0;
        op = 3'b000; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst_hi",   64'(hi),   64'(0));
        chk("rst_lo",   64'(lo),   64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_dbz",  64'(dbz),  64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Arithmetic, issued back-to-back in each Done cycle
        run_op("mult_neg",  3'b000, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
        run_op("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        run_op("div_neg",   3'b010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_op("divu_zero", 3'b011, 32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF, 1'b1);
        run_op("div_ovf",   3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
        run_op("div_negb",  3'b010, 32'd100,      32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 1'b0);
        @(negedge clk);

        // Moves and accumulate
        run_mt("mthi", 3'b100, 32'h12345678);
        chk("mthi_hi", 64'(hi), 64'(32'h12345678));
        run_mt("mtlo", 3'b101, 32'h00000001);
        chk("mtlo_lo", 64'(lo), 64'(32'h1));
        chk("mtlo_hi", 64'(hi), 64'(32'h12345678));
        run_op("madd",     3'b110, 32'd2,        32'd3, 32'h12345678, 32'h00000007, 1'b0);
        run_op("msub",     3'b111, 32'd1,        32'd8, 32'h12345677, 32'hFFFFFFFF, 1'b0);
        run_op("madd_neg", 3'b110, 32'hFFFFFFFF, 32'd1, 32'h12345677, 32'hFFFFFFFE, 1'b0);
        @(negedge clk);

        // Flush in RUN with stalls from Start-while-busy and ReadHiLo
        start = 1'b1; op = 3'b000; a = 32'd5; b = 32'd5;
        @(negedge clk);                 // cycle 1
        start = 1'b0;
        repeat (2) @(negedge clk);      // cycle 3
        start = 1'b1; op = 3'b100; a = 32'h0000AAAA;
        #1 chk("stall_on_start", 64'(stall), 64'(1));
        @(negedge clk);                 // cycle 4
        start = 1'b0; read_hilo = 1'b1;
        #1 chk("stall_on_read", 64'(stall), 64'(1));
        repeat (6) @(negedge clk);      // cycle 10
        chk("stall_before_flush", 64'(stall), 64'(1));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy",  64'(busy),  64'(0));
        chk("idle_nostall", 64'(stall), 64'(0));
        chk("flush_hi",    64'(hi),    64'(32'h12345677));
        chk("flush_lo",    64'(lo),    64'(32'hFFFFFFFE));
        @(negedge clk);
        chk("flush_nodone", 64'(done), 64'(0));
        read_hilo = 1'b0;

        // Flush during the commit cycle suppresses the write
        start = 1'b1; op = 3'b001; a = 32'd2; b = 32'd2;
        @(negedge clk);                 // cycle 1
        start = 1'b0;
        repeat (32) @(negedge clk);     // cycle 33 (FIXUP)
        chk("fixup_busy", 64'(busy), 64'(1));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("cflush_busy", 64'(busy), 64'(0));
        chk("cflush_done", 64'(done), 64'(0));
        chk("cflush_lo",   64'(lo),   64'(32'hFFFFFFFE));

        // Start together with Flush in IDLE is ignored
        start = 1'b1; flush = 1'b1; op = 3'b000; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("sflush_busy", 64'(busy), 64'(0));

        // Asynchronous reset in the middle of a DIV
        start = 1'b1; op = 3'b010; a = 32'd100; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_hi",   64'(hi),   64'(0));
        chk("arst_lo",   64'(lo),   64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_done", 64'(done), 64'(0));

        run_op("multu_after_rst", 3'b001, 32'd3, 32'd4, 32'h0, 32'd12, 1'b0);
        @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
